// File: rtl/edge_pkg.sv
// Shared types for the edge-window sequencer: controller states and the
// 3x3 tap bundle (p1 = top-left, p5 = centre, row-major).
package edge_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    FIRE   = 2'd1,
    WAIT   = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] p1;
    logic [PIX_W_DEF-1:0] p2;
    logic [PIX_W_DEF-1:0] p3;
    logic [PIX_W_DEF-1:0] p4;
    logic [PIX_W_DEF-1:0] p5;
    logic [PIX_W_DEF-1:0] p6;
    logic [PIX_W_DEF-1:0] p7;
    logic [PIX_W_DEF-1:0] p8;
    logic [PIX_W_DEF-1:0] p9;
  } window_t;

endpackage

// File: rtl/edge_line_buffer.sv
// Two stacked line buffers: lb0 holds the previous row, lb1 the row before it.
// Reads are combinational at the current column; contents are never cleared.
module edge_line_buffer
  import edge_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(IMG_W)-1:0] col,
  input  logic [PIX_W-1:0]         din,
  output logic [PIX_W-1:0]         lb0_q,
  output logic [PIX_W-1:0]         lb1_q
);

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  assign lb0_q = lb0[col];
  assign lb1_q = lb1[col];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1[col] <= lb0[col];
      lb0[col] <= din;
    end
  end

endmodule

// File: rtl/edge_window_ctrl.sv
// Builds 3x3 windows from a raster stream and hands each interior window to
// the edge-detect core, stalling input until the core finishes or times out.
//
//   state  | meaning
//   ACCEPT | pix_ready high, shifting pixels into the window
//   FIRE   | start pulse, window taps valid
//   WAIT   | waiting for core_done or timeout
module edge_window_ctrl
  import edge_pkg::*;
#(
  parameter int PIX_W       = PIX_W_DEF,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [PIX_W-1:0]         pixel_1_bin,
  output logic [PIX_W-1:0]         pixel_2_bin,
  output logic [PIX_W-1:0]         pixel_3_bin,
  output logic [PIX_W-1:0]         pixel_4_bin,
  output logic [PIX_W-1:0]         pixel_5_bin,
  output logic [PIX_W-1:0]         pixel_6_bin,
  output logic [PIX_W-1:0]         pixel_7_bin,
  output logic [PIX_W-1:0]         pixel_8_bin,
  output logic [PIX_W-1:0]         pixel_9_bin,
  output logic                     start,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  input  logic                     core_done,
  output logic                     frame_done,
  output logic                     err
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FINAL = RW'(IMG_H - 2);
  localparam logic [RW-1:0] ROW_TWO   = RW'(2);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FINAL = CW'(IMG_W - 2);
  localparam logic [CW-1:0] COL_TWO   = CW'(2);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYC - 1);

  ctrl_state_e      state, state_nxt;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [TW-1:0]    tmo_cnt;
  logic [PIX_W-1:0] tap [9];
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic             xfer, fire, wait_exit, last_win;

  edge_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_line_buf (
    .clk   (clk),
    .wr_en (xfer),
    .col   (col),
    .din   (pix_in),
    .lb0_q (lb0_q),
    .lb1_q (lb1_q)
  );

  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    xfer       = 1'b0;
    fire       = 1'b0;
    wait_exit  = 1'b0;
    last_win   = (win_row == ROW_FINAL) && (win_col == COL_FINAL);
    case (state)
      ACCEPT: begin
        pix_ready = !reset;
        xfer      = pix_valid && !reset;
        // col>=2 keeps windows from mixing the tail of the previous row
        fire      = xfer && (row >= ROW_TWO) && (col >= COL_TWO);
        if (fire) state_nxt = FIRE;
      end
      FIRE: begin
        start     = !reset;
        state_nxt = WAIT;
      end
      WAIT: begin
        wait_exit  = core_done || (tmo_cnt == '0);
        frame_done = !reset && wait_exit && last_win;
        if (wait_exit) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCEPT;
      row     <= '0;
      col     <= '0;
      tmo_cnt <= '0;
      err     <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      for (int k = 0; k < 9; k++) tap[k] <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        tap[0] <= tap[1];
        tap[1] <= tap[2];
        tap[2] <= lb1_q;
        tap[3] <= tap[4];
        tap[4] <= tap[5];
        tap[5] <= lb0_q;
        tap[6] <= tap[7];
        tap[7] <= tap[8];
        tap[8] <= pix_in;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (fire) begin
          win_row <= row - 1'b1;
          win_col <= col - 1'b1;
        end
      end
      if (state == FIRE)
        tmo_cnt <= TMO_LOAD;
      else if (state == WAIT && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;
      if (state == WAIT && !core_done && tmo_cnt == '0)
        err <= 1'b1;
    end
  end

  assign pixel_1_bin = tap[0];
  assign pixel_2_bin = tap[1];
  assign pixel_3_bin = tap[2];
  assign pixel_4_bin = tap[3];
  assign pixel_5_bin = tap[4];
  assign pixel_6_bin = tap[5];
  assign pixel_7_bin = tap[6];
  assign pixel_8_bin = tap[7];
  assign pixel_9_bin = tap[8];

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Self-checking bench for edge_window_ctrl on a 4x4 frame with an 8-cycle timeout.
module tb_edge_window_ctrl;
  import edge_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int T  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic          core_done = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_ready, start, frame_done, err;
  logic [1:0]    win_row, win_col;
  logic [PW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  window_t       act_win;

  assign act_win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  always #5 clk = ~clk;

  edge_window_ctrl #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pixel_1_bin(p1), .pixel_2_bin(p2), .pixel_3_bin(p3),
    .pixel_4_bin(p4), .pixel_5_bin(p5), .pixel_6_bin(p6),
    .pixel_7_bin(p7), .pixel_8_bin(p8), .pixel_9_bin(p9),
    .start(start), .win_row(win_row), .win_col(win_col),
    .core_done(core_done), .frame_done(frame_done), .err(err)
  );

  // Expected start events for a raster frame (pixel = 16*row+col), done 3 cycles after start
  typedef struct {
    int      cyc;
    int      row;
    int      col;
    window_t win;
  } vec_t;
  vec_t tbl [4];
  localparam int FD_CYC_EXP = 31;

  int checks = 0;
  int errors = 0;

  // Reference model: raster position, frame memory and handshake phase
  int      fm [H][W];
  int      mr, mc, phase, wait_n, cyc, xfers, fd_seen, fd_cyc;
  bit      m_err, cur_last;
  int      cur_r, cur_c;
  window_t cur_win;
  int      log_cyc [$];
  int      log_row [$];
  int      log_col [$];
  window_t log_win [$];
  int      done_mode, vrate;
  bit      raster;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    pix_valid = (vrate >= 100) ? 1'b1 : ($urandom_range(0, 99) < vrate);
    pix_in    = raster ? PW'(16 * mr + mc) : PW'($urandom_range(0, 255));
    case (done_mode)
      0:       core_done = (phase == 2 && wait_n == 2);
      1:       core_done = 1'b0;
      2:       core_done = ($urandom_range(0, 3) == 0);
      default: core_done = (phase != 2) || (wait_n == 2);
    endcase
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; phase = 0; wait_n = 0; m_err = 0;
    cyc = 0; xfers = 0; fd_seen = 0; fd_cyc = -1; cur_last = 0;
    log_cyc.delete(); log_row.delete(); log_col.delete(); log_win.delete();
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1; pix_valid = 1'b0; core_done = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_ready", pix_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    chk("rst_win_pos", {win_row, win_col}, 0);
    chk("rst_taps", act_win, 0);
    reset = 1'b0;
    model_reset();
    drive();
    #1 chk("ready_after_release", pix_ready, 1);
  endtask

  // One clock: advance the model with the inputs the DUT just sampled,
  // drive the next inputs, then compare outputs mid-cycle.
  task automatic step();
    logic [71:0] v;
    bit          exp_exit;
    @(posedge clk);
    cyc++;
    if (phase == 0) begin
      if (pix_valid) begin
        xfers++;
        fm[mr][mc] = int'(pix_in);
        if (mr >= 2 && mc >= 2) begin
          phase    = 1;
          cur_r    = mr - 1;
          cur_c    = mc - 1;
          cur_last = (cur_r == H - 2) && (cur_c == W - 2);
          v = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              v[(8 - (3 * i + j)) * 8 +: 8] = PW'(fm[mr - 2 + i][mc - 2 + j]);
          cur_win = v;
        end
        if (mc == W - 1) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end else if (phase == 1) begin
      phase = 2; wait_n = 0;
    end else begin
      if (core_done) phase = 0;
      else if (wait_n == T - 1) begin phase = 0; m_err = 1; end
      else wait_n++;
    end
    #1 drive();
    @(negedge clk);
    exp_exit = (phase == 2) && (core_done || wait_n == T - 1);
    chk("pix_ready", pix_ready, phase == 0);
    chk("start", start, phase == 1);
    chk("frame_done", frame_done, exp_exit && cur_last);
    chk("err", err, m_err);
    if (start) begin
      log_cyc.push_back(cyc);
      log_row.push_back(int'(win_row));
      log_col.push_back(int'(win_col));
      log_win.push_back(act_win);
      if (phase == 1) begin
        chk("win_row", win_row, cur_r);
        chk("win_col", win_col, cur_c);
        chk("taps", act_win, cur_win);
      end
    end
    if (frame_done) begin
      fd_seen++;
      fd_cyc = cyc;
    end
  endtask

  task automatic run_until_fd(input int nfd, input int budget);
    int n = 0;
    while (fd_seen < nfd && n < budget) begin
      step();
      n++;
    end
    chk("frame_budget", fd_seen, nfd);
  endtask

  task automatic check_table();
    chk("start_count", log_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_cyc.size()) begin
        chk("tbl_cycle", log_cyc[i], tbl[i].cyc);
        chk("tbl_row", log_row[i], tbl[i].row);
        chk("tbl_col", log_col[i], tbl[i].col);
        chk("tbl_taps", log_win[i], tbl[i].win);
      end
    end
    chk("frame_done_cycle", fd_cyc, FD_CYC_EXP);
  endtask

  initial begin
    tbl[0] = '{cyc: 11, row: 1, col: 1,
               win: {8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34}};
    tbl[1] = '{cyc: 16, row: 1, col: 2,
               win: {8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35}};
    tbl[2] = '{cyc: 23, row: 2, col: 1,
               win: {8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34, 8'd48, 8'd49, 8'd50}};
    tbl[3] = '{cyc: 28, row: 2, col: 2,
               win: {8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35, 8'd49, 8'd50, 8'd51}};

    model_reset();
    vrate = 100; raster = 1; done_mode = 0;

    // Reset held three cycles, then a full raster frame with done 3 cycles after start
    apply_reset(3);
    run_until_fd(1, 200);
    check_table();
    chk("pixels_consumed", xfers, 16);

    // Core never answers: every window times out, frame still completes
    apply_reset(2);
    done_mode = 1;
    run_until_fd(1, 400);
    chk("timeout_starts", log_cyc.size(), 4);
    chk("timeout_err", err, 1);

    // Reset after six transfers, then the same frame again
    apply_reset(2);
    done_mode = 0;
    for (int n = 0; n < 50 && xfers < 6; n++) step();
    chk("partial_xfers", xfers, 6);
    apply_reset(1);
    run_until_fd(1, 200);
    check_table();
    chk("err_cleared", err, 0);

    // core_done asserted in ACCEPT and in the start cycle must be ignored
    apply_reset(2);
    done_mode = 3;
    run_until_fd(1, 200);
    check_table();

    // Random pixels, random valid gaps, random core_done (including timeouts)
    apply_reset(2);
    raster = 0; vrate = 60; done_mode = 2;
    run_until_fd(3, 3000);
    chk("random_starts", log_cyc.size(), 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
